// File: rtl/cos_sched_pkg.sv
// Shared types and default sizing for the cosine-accelerator job scheduler.
package cos_sched_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int XW_DEF      = 16;
  localparam int RW_DEF      = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cos_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  // Walk offsets from the farthest to the nearest so the nearest requester overwrites.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last) + k) % N;
      if (req[cand]) begin
        idx   = IW'(cand);
        valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = valid && (idx == IW'(gi));
  end

endmodule

// File: rtl/cos_job_scheduler.sv
// Shares one cosine accelerator among N_REQ requesters: arbitrate, issue, wait with timeout, respond.
module cos_job_scheduler
  import cos_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int XW      = XW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*XW-1:0] req_x,
  output logic [N_REQ-1:0]    gnt,
  output logic                acc_start,
  output logic [XW-1:0]       acc_x,
  input  logic                acc_done,
  input  logic [RW-1:0]       acc_result,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [RW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     winner_q, winner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              acc_start_q, acc_start_d;
  logic [XW-1:0]     acc_x_q, acc_x_d;
  logic [RW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [N_REQ-1:0]  winner_onehot;
  logic              timeout_hit;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_win
    assign winner_onehot[gi] = (winner_q == IW'(gi));
  end

  // Fires on the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT cycles.
  assign timeout_hit = (int'(cnt_q) + 1) >= TIMEOUT;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    acc_start_d = 1'b0;
    acc_x_d     = acc_x_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_ISSUE;
          winner_d    = arb_idx;
          acc_x_d     = req_x[int'(arb_idx)*XW +: XW];
          gnt_d       = arb_grant;
          acc_start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (acc_done) begin
          state_d     = ST_RESP;
          rsp_data_d  = acc_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = winner_onehot;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = winner_onehot;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = winner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      last_q      <= IW'(N_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      acc_start_q <= 1'b0;
      acc_x_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      acc_start_q <= acc_start_d;
      acc_x_q     <= acc_x_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign acc_start = acc_start_q;
  assign acc_x     = acc_x_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
